// File: rtl/mem_access_sequencer.sv
// Memory slot sequencer: arbitrates the single-port memory between instruction
// fetch at the PC and load/store requests, and drives the PC counter's rw control.
module mem_access_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc,
  output logic [1:0]        rw,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_instr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam logic [1:0] ST_HALT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  localparam logic [1:0] RW_ADVANCE = 2'b00;
  localparam logic [1:0] RW_READ    = 2'b01;
  localparam logic [1:0] RW_WRITE   = 2'b10;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [3:0]        burst_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              active;
  logic              decision;
  logic              pick_data;
  logic              fetch_done;
  logic              data_done;

  // Handshake: the requester holds d_req (with d_we/d_addr/d_wdata stable) until
  // a cycle where d_gnt = 1; that cycle transfers the request and the requester
  // may drop or replace it on the next cycle. d_done pulses once per granted request.
  always_comb begin
    active     = (state == ST_FETCH) || (state == ST_DATA);
    decision   = !active || mem_ready;
    pick_data  = run && d_req && (burst_cnt < BURST_LIMIT);
    fetch_done = (state == ST_FETCH) && mem_ready;
    data_done  = (state == ST_DATA) && mem_ready;
    d_gnt      = !reset && decision && pick_data;

    state_next = state;
    if (decision) begin
      if (!run)           state_next = ST_HALT;
      else if (pick_data) state_next = ST_DATA;
      else                state_next = ST_FETCH;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    mem_wdata = wdata_q;
    rw        = RW_READ;
    case (state)
      ST_FETCH: begin
        mem_en = 1'b1;
        // PC must not advance on a completion that reset is discarding.
        rw     = (mem_ready && !reset) ? RW_ADVANCE : RW_READ;
      end
      ST_DATA: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        mem_addr = addr_q;
        rw       = we_q ? RW_WRITE : RW_READ;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HALT;
      burst_cnt <= 4'd0;
      d_done    <= 1'b0;
      i_valid   <= 1'b0;
      i_instr   <= '0;
      d_rdata   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state <= state_next;
      if (decision && run) begin
        if (pick_data) begin
          burst_cnt <= burst_cnt + 4'd1;
          we_q      <= d_we;
          addr_q    <= d_addr;
          wdata_q   <= d_wdata;
        end else begin
          burst_cnt <= 4'd0;
        end
      end
      i_valid <= fetch_done;
      if (fetch_done) i_instr <= mem_rdata;
      d_done <= data_done;
      if (data_done && !we_q) d_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: a vector table for the basic flow plus
// hand-written sequences for wait states, bursts, halting and reset mid-access.
module tb_mem_access_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [7:0] pc;
  logic [1:0] rw;
  logic       d_req = 1'b0;
  logic       d_we = 1'b0;
  logic [7:0] d_addr = 8'h00;
  logic [7:0] d_wdata = 8'h00;
  logic       d_gnt;
  logic       d_done;
  logic [7:0] d_rdata;
  logic       i_valid;
  logic [7:0] i_instr;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready = 1'b0;
  logic       busy;

  logic       pc_set = 1'b0;
  logic [7:0] pc_set_val = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_sequencer #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .run(run), .pc(pc), .rw(rw),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .i_valid(i_valid), .i_instr(i_instr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  // clock/reset block, PC counter model and memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_set)              pc <= pc_set_val;
    else if (rw == 2'b00)    pc <= pc + 8'd1;
  end

  assign mem_rdata = ~mem_addr;

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic do_reset(input logic [7:0] pcv);
    @(negedge clk);
    reset = 1'b1; pc_set = 1'b1; pc_set_val = pcv;
    run = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; pc_set = 1'b0;
  endtask

  task automatic drive(input logic r, input logic dq, input logic we,
                       input logic [7:0] a, input logic [7:0] wd, input logic rdy);
    @(negedge clk);
    run = r; d_req = dq; d_we = we; d_addr = a; d_wdata = wd; mem_ready = rdy;
    #1;
  endtask

  typedef struct {
    logic       run, dreq, we;
    logic [7:0] daddr, dwdata;
    logic       rdy;
    logic       e_gnt;
    logic [1:0] e_rw;
    logic       e_en, e_we;
    logic [7:0] e_addr, e_wdata;
    logic       e_ival;
    logic [7:0] e_instr;
    logic       e_done;
    logic [7:0] e_rdata;
    logic       e_busy;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int ivalid_cnt;
    logic [7:0] pc_before;

    vecs[0]  = '{1,0,0,8'h00,8'h00,1, 0,2'b01,0,0,8'h00,8'h00,0,8'h00,0,8'h00,0};
    vecs[1]  = '{1,0,0,8'h00,8'h00,1, 0,2'b00,1,0,8'h00,8'h00,0,8'h00,0,8'h00,1};
    vecs[2]  = '{1,0,0,8'h00,8'h00,1, 0,2'b00,1,0,8'h01,8'h00,1,8'hFF,0,8'h00,1};
    vecs[3]  = '{1,1,1,8'h80,8'h5A,1, 1,2'b00,1,0,8'h02,8'h00,1,8'hFE,0,8'h00,1};
    vecs[4]  = '{1,0,0,8'h00,8'h00,1, 0,2'b10,1,1,8'h80,8'h5A,1,8'hFD,0,8'h00,1};
    vecs[5]  = '{1,0,0,8'h00,8'h00,0, 0,2'b01,1,0,8'h03,8'h00,0,8'h00,1,8'h00,1};
    vecs[6]  = '{1,0,0,8'h00,8'h00,0, 0,2'b01,1,0,8'h03,8'h00,0,8'h00,0,8'h00,1};
    vecs[7]  = '{1,0,0,8'h00,8'h00,1, 0,2'b00,1,0,8'h03,8'h00,0,8'h00,0,8'h00,1};
    vecs[8]  = '{0,0,0,8'h00,8'h00,1, 0,2'b00,1,0,8'h04,8'h00,1,8'hFC,0,8'h00,1};
    vecs[9]  = '{0,0,0,8'h00,8'h00,1, 0,2'b01,0,0,8'h05,8'h00,1,8'hFB,0,8'h00,0};
    vecs[10] = '{0,0,0,8'h00,8'h00,1, 0,2'b01,0,0,8'h05,8'h00,0,8'h00,0,8'h00,0};

    // reset state
    do_reset(8'h00);
    #1;
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_rw", rw, 2'b01);
    check("rst_i_valid", i_valid, 0);
    check("rst_d_done", d_done, 0);
    check("rst_i_instr", i_instr, 8'h00);
    check("rst_d_rdata", d_rdata, 8'h00);

    // table: zero-wait fetches, store slotted in after a fetch, wait states, halt
    for (int k = 0; k < 11; k++) begin
      drive(vecs[k].run, vecs[k].dreq, vecs[k].we, vecs[k].daddr, vecs[k].dwdata, vecs[k].rdy);
      check($sformatf("v%0d_d_gnt", k), d_gnt, vecs[k].e_gnt);
      check($sformatf("v%0d_rw", k), rw, vecs[k].e_rw);
      check($sformatf("v%0d_mem_en", k), mem_en, vecs[k].e_en);
      check($sformatf("v%0d_mem_we", k), mem_we, vecs[k].e_we);
      check($sformatf("v%0d_mem_addr", k), mem_addr, vecs[k].e_addr);
      if (vecs[k].e_we) check($sformatf("v%0d_mem_wdata", k), mem_wdata, vecs[k].e_wdata);
      check($sformatf("v%0d_i_valid", k), i_valid, vecs[k].e_ival);
      if (vecs[k].e_ival) check($sformatf("v%0d_i_instr", k), i_instr, vecs[k].e_instr);
      check($sformatf("v%0d_d_done", k), d_done, vecs[k].e_done);
      if (vecs[k].e_done) check($sformatf("v%0d_d_rdata", k), d_rdata, vecs[k].e_rdata);
      check($sformatf("v%0d_busy", k), busy, vecs[k].e_busy);
    end

    // fetch with three wait states at pc 0x10
    do_reset(8'h10);
    drive(1, 0, 0, 8'h00, 8'h00, 0);
    check("ws_halt_rw", rw, 2'b01);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 8'h00, 8'h00, 0);
      check($sformatf("ws%0d_rw", k), rw, 2'b01);
      check($sformatf("ws%0d_addr", k), mem_addr, 8'h10);
      check($sformatf("ws%0d_en", k), mem_en, 1);
      check($sformatf("ws%0d_ival", k), i_valid, 0);
    end
    drive(0, 0, 0, 8'h00, 8'h00, 1);
    check("ws_done_rw", rw, 2'b00);
    check("ws_done_addr", mem_addr, 8'h10);
    ivalid_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 8'h00, 8'h00, 1);
      if (i_valid) begin
        ivalid_cnt++;
        check("ws_instr", i_instr, 8'hEF);
      end
    end
    check("ws_ivalid_count", ivalid_cnt, 1);
    check("ws_pc", pc, 8'h11);

    // continuous loads: D D D D F pattern, PC advances once per five slots
    do_reset(8'h00);
    drive(1, 1, 0, 8'h60, 8'h00, 1);
    check("bu_halt_gnt", d_gnt, 1);
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 8'h60, 8'h00, 1);
      check($sformatf("bu%0d_rw", i), rw, (i % 5 == 4) ? 2'b00 : 2'b01);
      check($sformatf("bu%0d_gnt", i), d_gnt, (i % 5 != 3));
      check($sformatf("bu%0d_ival", i), i_valid, (i % 5 == 0) && (i > 0));
      if (i % 5 != 4) check($sformatf("bu%0d_addr", i), mem_addr, 8'h60);
    end
    drive(0, 0, 0, 8'h00, 8'h00, 1);
    check("bu_pc", pc, 8'h04);

    // load in flight while run drops: completes, then halts
    do_reset(8'h20);
    drive(1, 1, 0, 8'h44, 8'h00, 0);
    check("ld_gnt", d_gnt, 1);
    drive(0, 0, 0, 8'h00, 8'h00, 0);
    check("ld_rw", rw, 2'b01);
    check("ld_addr", mem_addr, 8'h44);
    check("ld_en", mem_en, 1);
    check("ld_we", mem_we, 0);
    check("ld_busy", busy, 1);
    drive(0, 0, 0, 8'h00, 8'h00, 0);
    check("ld_wait_done", d_done, 0);
    drive(0, 0, 0, 8'h00, 8'h00, 1);
    check("ld_cmpl_rw", rw, 2'b01);
    check("ld_cmpl_gnt", d_gnt, 0);
    drive(0, 0, 0, 8'h00, 8'h00, 1);
    check("ld_done", d_done, 1);
    check("ld_rdata", d_rdata, 8'hBB);
    check("ld_halt_busy", busy, 0);
    check("ld_halt_en", mem_en, 0);
    check("ld_halt_rw", rw, 2'b01);
    check("ld_pc", pc, 8'h20);
    drive(0, 0, 0, 8'h00, 8'h00, 1);
    check("ld_done_pulse", d_done, 0);
    check("ld_rdata_hold", d_rdata, 8'hBB);

    // reset arriving mid-store with memory stalled
    do_reset(8'h30);
    drive(1, 1, 1, 8'h90, 8'h33, 0);
    check("rs_gnt", d_gnt, 1);
    drive(1, 0, 0, 8'h00, 8'h00, 0);
    check("rs_rw", rw, 2'b10);
    check("rs_we", mem_we, 1);
    check("rs_addr", mem_addr, 8'h90);
    check("rs_wdata", mem_wdata, 8'h33);
    pc_before = pc;
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
    #1;
    check("rs_busy", busy, 0);
    check("rs_en", mem_en, 0);
    check("rs_done", d_done, 0);
    check("rs_pc", pc, pc_before);
    drive(0, 0, 0, 8'h00, 8'h00, 1);
    check("rs_done_late", d_done, 0);
    check("rs_pc_late", pc, 8'h30);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sequences the single-port program/data memory of the processor core and drives the 2-bit rw control of the 8-bit PC counter.
- Arbitrates each memory slot between instruction fetch (at the PC value) and load/store requests from the execute stage.
- Data requests have priority over fetch, but a burst cap guarantees forward progress of fetch.
- The PC advances exactly once per completed fetch and holds on every other cycle.

Parameters:
- ADDR_W, 8, memory address width; matches the PC counter width.
- DATA_W, 8, memory/instruction data width.
- MAX_BURST, 4, maximum consecutive data grants before one fetch is forced; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = execute; 0 = halt at the next decision point.
- pc  in  ADDR_W  current PC counter value (counter count output).
- rw  out  2  PC counter control: 00 = advance, 01 = hold/read, 10 = hold/write. 11 is never driven.
- d_req  in  1  data access request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load; qualified by d_req.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  combinational; request accepted this cycle.
- d_done  out  1  registered one-cycle pulse: data access finished.
- d_rdata  out  DATA_W  registered load data; valid with d_done, held until the next load.
- i_valid  out  1  registered one-cycle pulse: fetched instruction valid.
- i_instr  out  DATA_W  registered instruction; held between pulses.
- mem_en  out  1  memory access active.
- mem_we  out  1  write strobe; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready = 1.
- mem_ready  in  1  access completes on a cycle with mem_en = 1 and mem_ready = 1; ignored when mem_en = 0.
- busy  out  1  state != HALT.

Behaviour:
- States: HALT (reset state), FETCH, DATA. The 2-bit state register is also visible via busy.
- Reset (synchronous, highest priority):
  - state = HALT, burst_cnt = 0.
  - d_done, i_valid, i_instr, d_rdata = 0.
  - Any in-flight access is dropped: no d_done, no i_valid, no PC advance.
- Decision point: any cycle in HALT, or the completion cycle (mem_ready = 1) of FETCH or DATA. The registered next state is chosen as follows:
  - run = 0 → HALT.
  - run = 1 and d_req = 1 and burst_cnt < MAX_BURST → DATA. Assert d_gnt this cycle; latch d_we, d_addr, d_wdata; burst_cnt += 1.
  - Otherwise, with run = 1 → FETCH; burst_cnt = 0.
- d_gnt is 0 on all non-decision cycles. At most one data access is outstanding.
- FETCH:
  - mem_en = 1, mem_we = 0, mem_addr = pc (live), rw = 01 while waiting.
  - On the completion cycle rw = 00, so the PC increments on that edge. i_valid = 1 and i_instr = mem_rdata on the following cycle.
- DATA:
  - mem_en = 1, mem_we = latched we, mem_addr and mem_wdata = latched values.
  - rw = 10 for a store, 01 for a load, on every cycle including completion; the PC never advances.
  - d_done is asserted the cycle after completion. For a load, d_rdata = mem_rdata captured at completion; for a store, d_rdata is unchanged.
- HALT: mem_en = 0, mem_we = 0, rw = 01, mem_addr = pc.
- run falling during an access does not abort it. The access completes normally, then the block enters HALT.
- Back-to-back accesses: mem_en stays high across a decision point that selects FETCH or DATA, so there are no bubbles. Zero-wait memory (mem_ready tied high) yields one access per cycle.
- burst_cnt saturates at MAX_BURST; it can only reach MAX_BURST via data grants and clears on a fetch grant. With MAX_BURST = 4 and d_req held high, the slot pattern is D D D D F D D D D F …
- PC wrap 0xFF → 0x00 is handled by the counter. The sequencer treats pc opaquely.

Test Plan:
- Reset then run = 1, d_req = 0, mem_ready = 1, pc starting at 0x00 → mem_addr 00, 01, 02 … on consecutive cycles; rw = 00 every cycle; i_valid every cycle one cycle later with i_instr = mem_rdata.
- mem_ready low for 3 cycles during a fetch at pc = 0x10 → rw = 01 for 3 cycles, then 00 once; exactly one i_valid; mem_addr stable at 0x10.
- Store d_addr = 0x80, d_wdata = 0x5A during a fetch → d_gnt at fetch completion; next slot mem_we = 1, addr 0x80, data 0x5A, rw = 10; d_done 1 cycle after completion; pc unchanged.
- d_req held high continuously with loads, MAX_BURST = 4, mem_ready = 1 → grant pattern D D D D F repeats; the PC advances once per 5 cycles.
- Load in flight (mem_ready low), run drops → load completes, d_done and d_rdata correct, then HALT: busy = 0, mem_en = 0, rw = 01.
- reset asserted mid-DATA with mem_ready low → next cycle state is HALT, mem_en = 0, no d_done, pc unchanged.
